// File: rtl/spi_burst_rx_if.sv
// Control, serial and result signals of the SPI burst receiver.
// The master side starts bursts and drives sck/miso; the slave side is the receiver.
interface spi_burst_rx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic              abort;
    logic [7:0]        burst_len;
    logic              sck;
    logic              miso;
    logic [DATA_W-1:0] op_data;
    logic              op_flag;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, burst_len, sck, miso,
        input  op_data, op_flag, busy, done
    );

    modport slave (
        input  start, abort, burst_len, sck, miso,
        output op_data, op_flag, busy, done
    );
endinterface

// File: rtl/spi_burst_rx.sv
// SPI slave receiver: oversamples sck/miso on clk and assembles DATA_W-bit words
// for a burst of up to MAX_BURST words, strobing each word and the end of the burst.
module spi_burst_rx #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 148,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic          clk,
    input logic          rst,
    spi_burst_rx_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [7:0]       MAX_LEN  = 8'(MAX_BURST);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]        state;
    logic              sck_s1, sck_s2, sck_s3;
    logic              miso_s1, miso_s2;
    logic              lead_edge, trail_edge, sample;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [7:0]        len, word_cnt;
    logic [DATA_W-1:0] op_data_r;
    logic              op_flag_r, done_r;

    // Sync flops start at the idle levels so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1  <= CPOL;
            sck_s2  <= CPOL;
            sck_s3  <= CPOL;
            miso_s1 <= 1'b1;
            miso_s2 <= 1'b1;
        end else begin
            sck_s1  <= bus.sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            miso_s1 <= bus.miso;
            miso_s2 <= miso_s1;
        end
    end

    assign lead_edge  = (sck_s3 == CPOL) && (sck_s2 != CPOL);
    assign trail_edge = (sck_s3 != CPOL) && (sck_s2 == CPOL);
    assign sample     = CPHA ? trail_edge : lead_edge;

    always_comb begin
        shreg_nxt = shreg;
        if (MSB_FIRST)
            shreg_nxt = {shreg[DATA_W-2:0], miso_s2};
        else
            shreg_nxt = {miso_s2, shreg[DATA_W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= 8'd0;
            bit_cnt   <= '0;
            word_cnt  <= 8'd0;
            shreg     <= '0;
            op_data_r <= '0;
            op_flag_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            op_flag_r <= 1'b0;
            done_r    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && (bus.burst_len != 8'd0)) begin
                        state    <= RECV;
                        len      <= (bus.burst_len > MAX_LEN) ? MAX_LEN : bus.burst_len;
                        bit_cnt  <= '0;
                        word_cnt <= 8'd0;
                        shreg    <= '0;
                    end
                end
                RECV: begin
                    // abort wins over any sample or completion in the same cycle
                    if (bus.abort) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        word_cnt <= 8'd0;
                        shreg    <= '0;
                    end else if (sample) begin
                        shreg <= shreg_nxt;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            op_data_r <= shreg_nxt;
                            op_flag_r <= 1'b1;
                            word_cnt  <= word_cnt + 8'd1;
                            if (word_cnt + 8'd1 == len) begin
                                done_r <= 1'b1;
                                state  <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.op_data = op_data_r;
    assign bus.op_flag = op_flag_r;
    assign bus.done    = done_r;
    assign bus.busy    = (state == RECV);
endmodule

// File: tb/tb_spi_burst_rx.sv
// Bench for spi_burst_rx: three configurations (mode 0 MSB/LSB first, mode 3 16-bit)
// driven by a table of bursts plus hand sequences, checked against a scoreboard.
module tb_spi_burst_rx;
    logic clk = 1'b0;
    logic rst;
    logic sck, sck2, miso;

    always #5 clk = ~clk;

    spi_burst_rx_if #(.DATA_W(8))  bus0 ();
    spi_burst_rx_if #(.DATA_W(8))  bus1 ();
    spi_burst_rx_if #(.DATA_W(16)) bus2 ();

    assign bus0.sck  = sck;
    assign bus1.sck  = sck;
    assign bus2.sck  = sck2;
    assign bus0.miso = miso;
    assign bus1.miso = miso;
    assign bus2.miso = miso;

    spi_burst_rx #(.DATA_W(8), .MAX_BURST(148), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    spi_burst_rx #(.DATA_W(8), .MAX_BURST(148), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0))
        u1 (.clk(clk), .rst(rst), .bus(bus1));
    spi_burst_rx #(.DATA_W(16), .MAX_BURST(148), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1))
        u2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic [31:0] data;
        logic        done;
    } exp_t;

    typedef struct {
        logic [7:0] blen;
        int         n;
        logic [7:0] w [4];
    } vec_t;

    exp_t q0[$], q1[$], q2[$];
    int   errors = 0;
    int   checks = 0;
    int   nflag0 = 0, nflag1 = 0, nflag2 = 0;
    int   ndone0 = 0, ndone1 = 0, ndone2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: each op_flag pops one expected {data, done} record.
    always @(negedge clk) begin
        exp_t e;
        if (bus0.op_flag) begin
            nflag0++;
            if (q0.size() == 0) check("u0_unexpected_flag", 32'(bus0.op_data), 32'hFFFF_FFFF);
            else begin
                e = q0.pop_front();
                check("u0_data", 32'(bus0.op_data), e.data);
                check("u0_done", 32'(bus0.done), 32'(e.done));
            end
        end else if (bus0.done) check("u0_done_without_flag", 32'd1, 32'd0);
        if (bus0.done) ndone0++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus1.op_flag) begin
            nflag1++;
            if (q1.size() == 0) check("u1_unexpected_flag", 32'(bus1.op_data), 32'hFFFF_FFFF);
            else begin
                e = q1.pop_front();
                check("u1_data", 32'(bus1.op_data), e.data);
                check("u1_done", 32'(bus1.done), 32'(e.done));
            end
        end else if (bus1.done) check("u1_done_without_flag", 32'd1, 32'd0);
        if (bus1.done) ndone1++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus2.op_flag) begin
            nflag2++;
            if (q2.size() == 0) check("u2_unexpected_flag", 32'(bus2.op_data), 32'hFFFF_FFFF);
            else begin
                e = q2.pop_front();
                check("u2_data", 32'(bus2.op_data), e.data);
                check("u2_done", 32'(bus2.done), 32'(e.done));
            end
        end else if (bus2.done) check("u2_done_without_flag", 32'd1, 32'd0);
        if (bus2.done) ndone2++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // alt=0: mode 0 on sck (sample on rise); alt=1: mode 3 on sck2 (sample on rise after fall)
    task automatic send_bit(input logic b, input bit alt);
        miso = b;
        if (!alt) begin
            tick(4); sck = 1'b1; tick(4); sck = 1'b0;
        end else begin
            sck2 = 1'b0; tick(4); sck2 = 1'b1; tick(4);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int dw, input bit lsb,
                             input bit alt, input int nbits);
        for (int i = 0; i < nbits; i++)
            send_bit(lsb ? w[i] : w[dw-1-i], alt);
    endtask

    task automatic start_burst(input int which, input logic [7:0] blen);
        case (which)
            0: begin bus0.start = 1'b1; bus0.burst_len = blen; end
            1: begin bus1.start = 1'b1; bus1.burst_len = blen; end
            default: begin bus2.start = 1'b1; bus2.burst_len = blen; end
        endcase
        tick(1);
        bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
    endtask

    vec_t vt[4];
    int   f0, d0, f1, f2;

    initial begin
        vt[0].blen = 8'd1; vt[0].n = 1; vt[0].w = '{8'hA5, 8'h00, 8'h00, 8'h00};
        vt[1].blen = 8'd3; vt[1].n = 3; vt[1].w = '{8'h01, 8'h02, 8'h03, 8'h00};
        vt[2].blen = 8'd2; vt[2].n = 2; vt[2].w = '{8'hFF, 8'h00, 8'h00, 8'h00};
        vt[3].blen = 8'd4; vt[3].n = 4; vt[3].w = '{8'h80, 8'h7F, 8'hC3, 8'h3C};

        rst = 1'b1; sck = 1'b0; sck2 = 1'b1; miso = 1'b1;
        bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
        bus0.abort = 1'b0; bus1.abort = 1'b0; bus2.abort = 1'b0;
        bus0.burst_len = 8'd0; bus1.burst_len = 8'd0; bus2.burst_len = 8'd0;
        tick(3);
        check("rst_u0_op_data", 32'(bus0.op_data), 32'd0);
        check("rst_u0_busy", 32'(bus0.busy), 32'd0);
        check("rst_u0_flag_done", 32'({bus0.op_flag, bus0.done}), 32'd0);
        check("rst_u2_op_data", 32'(bus2.op_data), 32'd0);
        check("rst_u2_busy", 32'(bus2.busy), 32'd0);
        rst = 1'b0;
        tick(2);

        // Table-driven bursts on the mode-0 MSB-first receiver
        for (int v = 0; v < 4; v++) begin
            f0 = nflag0; d0 = ndone0;
            start_burst(0, vt[v].blen);
            check("tbl_busy_after_start", 32'(bus0.busy), 32'd1);
            for (int k = 0; k < vt[v].n; k++) begin
                q0.push_back('{data: 32'(vt[v].w[k]), done: (k + 1 == int'(vt[v].blen))});
                send_word(32'(vt[v].w[k]), 8, 1'b0, 1'b0, 8);
            end
            tick(4);
            check("tbl_busy_end", 32'(bus0.busy), 32'd0);
            check("tbl_flag_count", 32'(nflag0 - f0), 32'(vt[v].n));
            check("tbl_done_count", 32'(ndone0 - d0), 32'd1);
            check("tbl_queue_empty", 32'(q0.size()), 32'd0);
        end

        // burst_len = 0 is ignored
        f0 = nflag0; d0 = ndone0;
        start_burst(0, 8'd0);
        check("zero_len_busy", 32'(bus0.busy), 32'd0);
        send_word(32'h5A, 8, 1'b0, 1'b0, 8);
        tick(4);
        check("zero_len_no_flag", 32'(nflag0 - f0), 32'd0);
        check("zero_len_no_done", 32'(ndone0 - d0), 32'd0);

        // start while receiving is ignored
        start_burst(0, 8'd2);
        q0.push_back('{data: 32'h3C, done: 1'b0});
        send_word(32'h3C, 8, 1'b0, 1'b0, 8);
        start_burst(0, 8'd5);
        check("restart_still_busy", 32'(bus0.busy), 32'd1);
        q0.push_back('{data: 32'hC3, done: 1'b1});
        send_word(32'hC3, 8, 1'b0, 1'b0, 8);
        tick(4);
        check("restart_busy_end", 32'(bus0.busy), 32'd0);
        check("restart_queue_empty", 32'(q0.size()), 32'd0);

        // burst_len beyond MAX_BURST is clamped; extra words produce nothing
        f0 = nflag0; d0 = ndone0;
        start_burst(0, 8'd200);
        for (int i = 0; i < 150; i++) begin
            if (i < 148) q0.push_back('{data: 32'(8'(i) ^ 8'h5A), done: (i == 147)});
            send_word(32'(8'(i) ^ 8'h5A), 8, 1'b0, 1'b0, 8);
        end
        tick(4);
        check("clamp_flag_count", 32'(nflag0 - f0), 32'd148);
        check("clamp_done_count", 32'(ndone0 - d0), 32'd1);
        check("clamp_queue_empty", 32'(q0.size()), 32'd0);
        check("clamp_busy", 32'(bus0.busy), 32'd0);

        // abort mid-word discards the partial word
        f0 = nflag0; d0 = ndone0;
        start_burst(0, 8'd4);
        q0.push_back('{data: 32'h11, done: 1'b0});
        send_word(32'h11, 8, 1'b0, 1'b0, 8);
        send_word(32'h96, 8, 1'b0, 1'b0, 5);
        tick(2);
        bus0.abort = 1'b1;
        tick(1);
        bus0.abort = 1'b0;
        check("abort_busy_low", 32'(bus0.busy), 32'd0);
        send_word(32'h96, 8, 1'b0, 1'b0, 3);
        tick(4);
        check("abort_flag_count", 32'(nflag0 - f0), 32'd1);
        check("abort_no_done", 32'(ndone0 - d0), 32'd0);
        check("abort_queue_empty", 32'(q0.size()), 32'd0);

        // LSB-first receiver: bits 1,0,1,0,0,1,0,1 assemble 0xA5
        f0 = nflag0; f1 = nflag1;
        start_burst(1, 8'd1);
        q1.push_back('{data: 32'hA5, done: 1'b1});
        send_word(32'hA5, 8, 1'b1, 1'b0, 8);
        tick(4);
        check("lsb_flag_count", 32'(nflag1 - f1), 32'd1);
        check("lsb_queue_empty", 32'(q1.size()), 32'd0);
        check("lsb_busy", 32'(bus1.busy), 32'd0);
        check("lsb_idle_u0_silent", 32'(nflag0 - f0), 32'd0);

        // CPOL=1 CPHA=1 16-bit word
        start_burst(2, 8'd1);
        q2.push_back('{data: 32'hBEEF, done: 1'b1});
        send_word(32'hBEEF, 16, 1'b0, 1'b1, 16);
        tick(4);
        check("m3_queue_empty", 32'(q2.size()), 32'd0);
        check("m3_op_data_hold", 32'(bus2.op_data), 32'hBEEF);

        // reset mid-word, with a start on another receiver coincident with reset
        start_burst(2, 8'd2);
        send_word(32'h1234, 16, 1'b0, 1'b1, 7);
        rst = 1'b1;
        bus0.start = 1'b1; bus0.burst_len = 8'd1;
        tick(1);
        check("rst_mid_op_data", 32'(bus2.op_data), 32'd0);
        check("rst_mid_outputs", 32'({bus2.op_flag, bus2.busy, bus2.done}), 32'd0);
        rst = 1'b0;
        bus0.start = 1'b0;
        tick(1);
        check("rst_mid_idle", 32'(bus2.busy), 32'd0);
        check("rst_start_ignored", 32'(bus0.busy), 32'd0);
        f2 = nflag2;
        send_word(32'h1234, 16, 1'b0, 1'b1, 9);
        tick(4);
        check("rst_mid_no_flag", 32'(nflag2 - f2), 32'd0);
        check("rst_mid_no_done", 32'(ndone2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
